// File: rtl/tut3_verilog_sort_sort_unit_seq.sv
// Sequential odd-even transposition sorter, one compare phase per cycle.
// Optional early exit on two swap-free phases: SORT_UNIT_SEQ_EARLY_EXIT_EN.
module tut3_verilog_sort_sort_unit_seq #(
  parameter  int p_nbits  = 8,
  parameter  int p_nelems = 4,
  localparam int PW       = $clog2(p_nelems + 1),
  localparam int MW       = p_nelems * p_nbits
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_val,
  output logic          in_rdy,
  input  logic [MW-1:0] in_msg,
  input  logic          in_descend,
  output logic          out_val,
  input  logic          out_rdy,
  output logic [MW-1:0] out_msg,
  output logic [PW-1:0] out_phases
);

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_e;

  state_e        state_q;
  logic [MW-1:0] work_q;
  logic [MW-1:0] work_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phases_q;
  logic          desc_q;
  logic          last;
  logic          done_now;

`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
  logic          swap_any;
  logic          prev_swap_q;
`endif

  always_comb begin
    logic [p_nbits-1:0] a;
    logic [p_nbits-1:0] b;
    a      = '0;
    b      = '0;
    work_d = work_q;
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
    swap_any = 1'b0;
`endif
    // Pairs within a phase are disjoint, so all read work_q directly.
    for (int i = 0; i < p_nelems - 1; i++) begin
      if (i[0] == phase_q[0]) begin
        a = work_q[i*p_nbits +: p_nbits];
        b = work_q[(i+1)*p_nbits +: p_nbits];
        if (desc_q ? (a < b) : (a > b)) begin
          work_d[i*p_nbits +: p_nbits]     = b;
          work_d[(i+1)*p_nbits +: p_nbits] = a;
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
          swap_any = 1'b1;
`endif
        end
      end
    end
  end

  assign last = (phase_q == PW'(p_nelems - 1));

`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
  assign done_now = last ||
    ((phase_q != '0) && !swap_any && !prev_swap_q);
`else
  assign done_now = last;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      phase_q  <= '0;
      phases_q <= '0;
      desc_q   <= 1'b0;
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
      prev_swap_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_val) begin
            work_q  <= in_msg;
            desc_q  <= in_descend;
            phase_q <= '0;
            state_q <= SORT;
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
            prev_swap_q <= 1'b0;
`endif
          end
        end
        SORT: begin
          work_q  <= work_d;
          phase_q <= phase_q + PW'(1);
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
          prev_swap_q <= swap_any;
`endif
          if (done_now) begin
            state_q  <= DONE;
            phases_q <= phase_q + PW'(1);
          end
        end
        DONE: begin
          if (out_rdy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_rdy     = reset && (state_q == IDLE);
  assign out_val    = (state_q == DONE);
  assign out_msg    = work_q;
  assign out_phases = phases_q;

endmodule

// File: tb/tb_tut3_verilog_sort_sort_unit_seq.sv
// Directed bench for the sequential sorter, p_nbits=8, p_nelems=4.
// Expected latencies follow SORT_UNIT_SEQ_EARLY_EXIT_EN when defined.
module tb_tut3_verilog_sort_sort_unit_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_msg;
  logic        in_descend;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg;
  logic [2:0]  out_phases;

  int errors = 0;
  int checks = 0;

  tut3_verilog_sort_sort_unit_seq #(
    .p_nbits (8),
    .p_nelems(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .in_descend(in_descend),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .out_phases(out_phases)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(
    input logic [7:0] e0, e1, e2, e3
  );
    return {e3, e2, e1, e0};
  endfunction

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(
    input logic [31:0] msg,
    input logic        desc,
    input logic [31:0] exp,
    input int          lat_full,
    input int          lat_ee,
    input bit          release_it
  );
    int lat;
    int exp_lat;
`ifdef SORT_UNIT_SEQ_EARLY_EXIT_EN
    exp_lat = lat_ee;
`else
    exp_lat = lat_full;
`endif
    chk("rdy_before", 32'(in_rdy), 32'd1);
    in_val     = 1'b1;
    in_msg     = msg;
    in_descend = desc;
    @(posedge clk);
    @(negedge clk);
    in_val     = 1'b0;
    in_msg     = 32'hdeadbeef;
    in_descend = ~desc;
    lat = 0;
    while (!out_val && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("out_msg", out_msg, exp);
    chk("out_phases", 32'(out_phases), 32'(exp_lat));
    if (release_it) begin
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_rdy = 1'b0;
      chk("val_after", 32'(out_val), 32'd0);
      chk("rdy_after", 32'(in_rdy), 32'd1);
    end
  endtask

  initial begin
    reset      = 1'b0;
    in_val     = 1'b0;
    in_msg     = '0;
    in_descend = 1'b0;
    out_rdy    = 1'b0;
    #2;
    chk("rst_rdy", 32'(in_rdy), 32'd0);
    chk("rst_val", 32'(out_val), 32'd0);
    chk("rst_msg", out_msg, 32'd0);
    chk("rst_ph", 32'(out_phases), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rdy_post_rst", 32'(in_rdy), 32'd1);
    @(negedge clk);

    send(pk(4, 3, 2, 1), 1'b0, pk(1, 2, 3, 4), 4, 4, 1);
    send(pk(1, 9, 0, 255), 1'b1, pk(255, 9, 1, 0), 4, 4, 1);
    send(pk(5, 5, 0, 5), 1'b0, pk(0, 5, 5, 5), 4, 4, 1);
    send(pk(1, 2, 3, 4), 1'b0, pk(1, 2, 3, 4), 4, 2, 1);

    // Back-pressure in DONE with a competing request on the input.
    send(pk(4, 3, 2, 1), 1'b1, pk(4, 3, 2, 1), 4, 2, 0);
    in_val = 1'b1;
    in_msg = pk(7, 7, 7, 0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_val", 32'(out_val), 32'd1);
      chk("hold_msg", out_msg, pk(4, 3, 2, 1));
      chk("hold_rdy", 32'(in_rdy), 32'd0);
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    chk("hold_exit_val", 32'(out_val), 32'd0);
    chk("hold_exit_rdy", 32'(in_rdy), 32'd1);
    chk("hold_exit_msg", out_msg, pk(4, 3, 2, 1));

    // Reset in the middle of SORT.
    in_val = 1'b1;
    in_msg = pk(9, 8, 7, 6);
    @(posedge clk);
    @(negedge clk);
    in_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_val", 32'(out_val), 32'd0);
      chk("mid_rst_rdy", 32'(in_rdy), 32'd0);
      @(posedge clk);
      #1;
    end
    chk("mid_rst_msg", out_msg, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ph", 32'(out_phases), 32'd0);
    @(negedge clk);
    send(pk(2, 1, 4, 3), 1'b0, pk(1, 2, 3, 4), 4, 3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
